mem_txn_fsm: RTL and testbench

- Transaction FSM sitting directly downstream of the host command port and upstream of the QSPI engine.
- Accepts a decoded read/write request (r_w, address, length) and a 256-bit write buffer from the command port.
- Sequences one QSPI transfer per request: streams read bytes back to the command port, or serialises the write buffer into the QSPI engine.
- Signals completion with a one-cycle txn_done pulse.

---
 rtl/mem_txn_fsm_if.sv | 36 +++
 rtl/mem_txn_fsm.sv | 165 ++++++++++++++++
 tb/tb_mem_txn_fsm.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_txn_fsm_if.sv
// mem_txn_fsm_if
//   Link between the transaction FSM and the QSPI engine.
//   master modport : mem_txn_fsm side (launches transfers, sinks rx, sources tx)
//   slave modport  : QSPI engine side
//   Signals:
//     qspi_start/rw/addr/len : transfer launch pulse and its parameters
//     qspi_busy              : engine busy, start only honoured when low
//     qspi_rx_valid/data/ready : read bytes engine -> FSM
//     qspi_tx_valid/data/ready : write bytes FSM -> engine
//     qspi_done              : transfer complete pulse
interface mem_txn_fsm_if;
   logic        qspi_start;
   logic        qspi_rw;
   logic [23:0] qspi_addr;
   logic [8:0]  qspi_len;
   logic        qspi_busy;
   logic        qspi_rx_valid;
   logic [7:0]  qspi_rx_data;
   logic        qspi_rx_ready;
   logic        qspi_tx_valid;
   logic [7:0]  qspi_tx_data;
   logic        qspi_tx_ready;
   logic        qspi_done;

   modport master (
      output qspi_start, qspi_rw, qspi_addr, qspi_len,
      output qspi_rx_ready, qspi_tx_valid, qspi_tx_data,
      input  qspi_busy, qspi_rx_valid, qspi_rx_data, qspi_tx_ready, qspi_done
   );

   modport slave (
      input  qspi_start, qspi_rw, qspi_addr, qspi_len,
      input  qspi_rx_ready, qspi_tx_valid, qspi_tx_data,
      output qspi_busy, qspi_rx_valid, qspi_rx_data, qspi_tx_ready, qspi_done
   );
endinterface

// File: rtl/mem_txn_fsm.sv
// mem_txn_fsm
//   Sequences one QSPI transfer per host request. Reads are streamed back
//   to the command port through a one-entry output register; writes are
//   serialised from a snapshot of the write buffer, most significant used
//   byte first. txn_done pulses for one cycle at the end of each request.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     ena, r_w, address_valid,
//     address, length_valid,
//     length                  : request from the command port
//     wr_data, wr_data_valid  : write buffer and its completion strobe
//     out_fsm_ready           : command port accepts a read byte
//     fsm_valid, fsm_data     : read byte toward the command port
//     fsm_ready               : idle, able to accept a request
//     txn_done, txn_err       : completion pulse, sticky error flag
//     qspi                    : QSPI engine link (master side)
module mem_txn_fsm #(
   parameter int unsigned WR_MAX_BYTES     = 32,
   parameter int unsigned WR_DEFAULT_BYTES = 32,
   parameter int unsigned DONE_TIMEOUT     = 1023
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          r_w,
   input  logic          address_valid,
   input  logic [23:0]   address,
   input  logic          length_valid,
   input  logic [8:0]    length,
   input  logic [255:0]  wr_data,
   input  logic          wr_data_valid,
   input  logic          out_fsm_ready,
   output logic          fsm_valid,
   output logic [7:0]    fsm_data,
   output logic          fsm_ready,
   output logic          txn_done,
   output logic          txn_err,
   mem_txn_fsm_if.master qspi
);

   localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_WDATA, ISSUE, RD_STREAM, WR_STREAM, WAIT_DONE, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [23:0]      addr_q;
   logic             rw_q;
   logic [8:0]       len_q, cnt, cnt_nxt, len_sel, tx_idx;
   logic [TMO_W-1:0] tmo;
   logic [255:0]     snap;
   logic             done_seen, accept, out_free, streaming;
   logic             rx_hs, tx_hs, early_done, tmo_hit;

   // Effective request length: default when no length given, writes clamped.
   always_comb begin
      len_sel = length_valid ? length : 9'(WR_DEFAULT_BYTES);
      if (!r_w && (len_sel > 9'(WR_MAX_BYTES)))
         len_sel = 9'(WR_MAX_BYTES);
   end

   always_comb begin
      accept    = (state == IDLE) && ena && address_valid;
      out_free  = !fsm_valid || out_fsm_ready;
      streaming = (state == RD_STREAM) || (state == WR_STREAM);

      fsm_ready          = (state == IDLE);
      txn_done           = (state == DONE);
      qspi.qspi_start    = (state == ISSUE) && !qspi.qspi_busy;
      qspi.qspi_rw       = rw_q;
      qspi.qspi_addr     = addr_q;
      qspi.qspi_len      = len_q;
      // Rx is accepted on the same edge the output register is popped.
      qspi.qspi_rx_ready = (state == RD_STREAM) && (cnt != len_q) && out_free;
      qspi.qspi_tx_valid = (state == WR_STREAM) && (cnt != len_q);

      rx_hs   = qspi.qspi_rx_valid && qspi.qspi_rx_ready;
      tx_hs   = qspi.qspi_tx_valid && qspi.qspi_tx_ready;
      cnt_nxt = cnt + {8'd0, rx_hs | tx_hs};

      // Byte i comes from buffer byte (len-1-i), counted from the LSB.
      tx_idx            = len_q - 9'd1 - cnt;
      qspi.qspi_tx_data = qspi.qspi_tx_valid ? 8'(snap >> {tx_idx, 3'b000}) : '0;

      // A done pulse during streaming is early unless it coincides with the last byte.
      early_done = qspi.qspi_done && streaming && (cnt_nxt != len_q);
      tmo_hit    = (state == WAIT_DONE) && !qspi.qspi_done && !done_seen &&
                   (tmo == TMO_W'(DONE_TIMEOUT - 1));

      state_nxt = state;
      case (state)
         IDLE:
            if (accept) begin
               if (len_sel == 9'd0) state_nxt = DONE;
               else if (r_w)        state_nxt = ISSUE;
               else                 state_nxt = WAIT_WDATA;
            end
         WAIT_WDATA:
            if (wr_data_valid) state_nxt = ISSUE;
         ISSUE:
            if (!qspi.qspi_busy) state_nxt = rw_q ? RD_STREAM : WR_STREAM;
         RD_STREAM:
            if ((cnt == len_q) && out_free) state_nxt = WAIT_DONE;
         WR_STREAM:
            if (cnt_nxt == len_q) state_nxt = WAIT_DONE;
         WAIT_DONE:
            if (qspi.qspi_done || done_seen || tmo_hit) state_nxt = DONE;
         DONE:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         rw_q      <= 1'b0;
         len_q     <= '0;
         cnt       <= '0;
         tmo       <= '0;
         snap      <= '0;
         fsm_valid <= 1'b0;
         fsm_data  <= '0;
         txn_err   <= 1'b0;
         done_seen <= 1'b0;
      end else begin
         if (accept) begin
            addr_q    <= address;
            rw_q      <= r_w;
            len_q     <= len_sel;
            cnt       <= '0;
            tmo       <= '0;
            txn_err   <= 1'b0;
            done_seen <= 1'b0;
         end
         if ((state == WAIT_WDATA) && wr_data_valid)
            snap <= wr_data;
         if (rx_hs || tx_hs)
            cnt <= cnt_nxt;
         if (state == RD_STREAM) begin
            if (rx_hs) begin
               fsm_data  <= qspi.qspi_rx_data;
               fsm_valid <= 1'b1;
            end else if (out_fsm_ready) begin
               fsm_valid <= 1'b0;
            end
         end
         // Remember a done seen while still streaming so WAIT_DONE does not miss it.
         if (qspi.qspi_done && streaming)
            done_seen <= 1'b1;
         if (early_done || tmo_hit)
            txn_err <= 1'b1;
         if (state == WAIT_DONE)
            tmo <= tmo + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_txn_fsm.sv
// tb_mem_txn_fsm
//   Self-checking bench for mem_txn_fsm. A behavioural QSPI engine and
//   command-port sink are driven cycle by cycle; expected byte streams,
//   lengths and error outcomes come from a queue-based model of the
//   request rules.
module tb_mem_txn_fsm;
   localparam int unsigned TMO = 1023;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena, r_w, address_valid, length_valid, wr_data_valid, out_fsm_ready;
   logic [23:0]  address;
   logic [8:0]   length;
   logic [255:0] wr_data;
   logic         fsm_valid, fsm_ready, txn_done, txn_err;
   logic [7:0]   fsm_data;

   int checks = 0;
   int errors = 0;

   mem_txn_fsm_if qif();

   mem_txn_fsm #(
      .WR_MAX_BYTES(32),
      .WR_DEFAULT_BYTES(32),
      .DONE_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .r_w(r_w),
      .address_valid(address_valid), .address(address),
      .length_valid(length_valid), .length(length),
      .wr_data(wr_data), .wr_data_valid(wr_data_valid),
      .out_fsm_ready(out_fsm_ready),
      .fsm_valid(fsm_valid), .fsm_data(fsm_data), .fsm_ready(fsm_ready),
      .txn_done(txn_done), .txn_err(txn_err),
      .qspi(qif)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] RST_EXP = {7'd0, 1'b1, 56'd0};

   function automatic logic [63:0] rst_vec();
      return {7'd0, fsm_ready, fsm_valid, fsm_data, txn_done, txn_err,
              qif.qspi_start, qif.qspi_rx_ready, qif.qspi_tx_valid, qif.qspi_tx_data,
              qif.qspi_rw, qif.qspi_addr, qif.qspi_len};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic engine_idle();
      qif.qspi_busy     = 1'b0;
      qif.qspi_rx_valid = 1'b0;
      qif.qspi_rx_data  = 8'h00;
      qif.qspi_tx_ready = 1'b0;
      qif.qspi_done     = 1'b0;
   endtask

   // One complete request. mode: 0 sink always ready, 1 toggling, 2 random.
   task automatic run_txn(input bit rw, input logic [23:0] addr, input logic [8:0] len_in,
                          input bit lv, input logic [255:0] wd, input int mode, input bit seq,
                          input bit no_done, input bit early, input bit abort, input int busy_n);
      int eff, cyc, popped, rx_idx, tx_cnt, start_cnt, done_cnt;
      int start_cyc, done_cyc, last_cyc, post, wdv_at, done_wait, xfer;
      bit rx_v, started, seen_done, done_sent, aborted;
      logic [7:0] exp_q[$];

      cyc = 0; popped = 0; rx_idx = 0; tx_cnt = 0; start_cnt = 0; done_cnt = 0;
      start_cyc = -1; done_cyc = -1; last_cyc = 0; post = 0;
      rx_v = 0; started = 0; seen_done = 0; done_sent = 0; aborted = 0;
      wdv_at    = $urandom_range(1, 3);
      done_wait = $urandom_range(0, 3);

      // Reference: effective length and the byte stream expected on the wire.
      eff = lv ? int'(len_in) : 32;
      if (!rw && eff > 32) eff = 32;
      for (int i = 0; i < eff; i++)
         exp_q.push_back(rw ? (seq ? 8'(i) : 8'($urandom)) : wd[8*(eff-1-i) +: 8]);

      @(negedge clk);
      ena = 1'b1; address_valid = 1'b1; r_w = rw; address = addr;
      length = len_in; length_valid = lv; wr_data = wd; wr_data_valid = 1'b0;
      out_fsm_ready = 1'b1;
      engine_idle();
      #1 chk("idle_ready", fsm_ready, 1);

      while (post < 3 && cyc < 3000 && !aborted) begin
         @(negedge clk);
         cyc++;
         if (!seen_done) begin
            // Junk strobes outside IDLE must be ignored.
            ena = 1'($urandom); address_valid = 1'($urandom); r_w = 1'($urandom);
            address = 24'($urandom); length = 9'($urandom); length_valid = 1'($urandom);
         end else begin
            ena = 1'b0; address_valid = 1'b0;
         end
         qif.qspi_busy = (cyc <= busy_n);
         if (!rw && cyc >= wdv_at) wr_data_valid = 1'b1;
         if (rw && started && !rx_v && rx_idx < eff && $urandom_range(0, 3) != 0) rx_v = 1;
         qif.qspi_rx_valid = rx_v;
         qif.qspi_rx_data  = rx_v ? exp_q[rx_idx] : 8'($urandom);
         qif.qspi_tx_ready = ($urandom_range(0, 3) != 0);
         case (mode)
            0:       out_fsm_ready = 1'b1;
            1:       out_fsm_ready = ((cyc % 2) == 1);
            default: out_fsm_ready = 1'($urandom);
         endcase
         qif.qspi_done = 1'b0;
         xfer = rw ? rx_idx : tx_cnt;
         if (started && !done_sent && !no_done) begin
            if (early && xfer == 1) begin
               qif.qspi_done = 1'b1; done_sent = 1;
            end else if (!early && xfer == eff) begin
               if (done_wait == 0) begin
                  qif.qspi_done = 1'b1; done_sent = 1;
               end else begin
                  done_wait--;
               end
            end
         end

         if (abort && rx_v && rx_idx == 2) begin
            #1;
            rst_n = 1'b0; ena = 1'b0; address_valid = 1'b0; wr_data_valid = 1'b0;
            engine_idle();
            #1 chk("async_rst_outputs", rst_vec(), RST_EXP);
            @(posedge clk);
            #1 chk("rst_held_outputs", rst_vec(), RST_EXP);
            @(negedge clk);
            rst_n = 1'b1;
            aborted = 1;
         end else begin
            #1;
            if (cyc == 1) begin
               chk("ready_drop", fsm_ready, 0);
               chk("err_clear", txn_err, 0);
            end
            if (qif.qspi_start) begin
               start_cnt++;
               if (start_cnt == 1) begin
                  start_cyc = cyc;
                  chk("start_addr", qif.qspi_addr, addr);
                  chk("start_len", qif.qspi_len, eff);
                  chk("start_rw", qif.qspi_rw, rw);
                  chk("start_not_busy", qif.qspi_busy, 0);
               end
               started = 1;
            end
            if (rw) begin
               if (fsm_valid && !out_fsm_ready) chk("rx_stall", qif.qspi_rx_ready, 0);
               if (fsm_valid && out_fsm_ready) begin
                  if (popped < eff) chk("rd_byte", fsm_data, exp_q[popped]);
                  else              chk("rd_extra", popped, eff);
                  popped++;
               end
               if (rx_v && qif.qspi_rx_ready) begin
                  rx_idx++; rx_v = 0; last_cyc = cyc;
               end
            end else if (qif.qspi_tx_valid && qif.qspi_tx_ready) begin
               if (tx_cnt < eff) chk("wr_byte", qif.qspi_tx_data, exp_q[tx_cnt]);
               else              chk("wr_extra", tx_cnt, eff);
               tx_cnt++; last_cyc = cyc;
            end
            if (txn_done) begin
               done_cnt++;
               if (done_cnt == 1) begin
                  done_cyc = cyc;
                  chk("done_err", txn_err, (no_done || early) ? 1 : 0);
               end
            end
            if (seen_done) post++;
            if (txn_done) seen_done = 1;
         end
      end

      ena = 1'b0; address_valid = 1'b0; wr_data_valid = 1'b0;
      engine_idle();
      if (!aborted) begin
         chk("done_within_budget", seen_done, 1);
         chk("done_once", done_cnt, 1);
         chk("start_once", start_cnt, (eff == 0) ? 0 : 1);
         chk("byte_count", rw ? popped : tx_cnt, eff);
         chk("ready_back", fsm_ready, 1);
         if (eff == 0) chk("len0_latency", (done_cyc >= 1 && done_cyc <= 2), 1);
         if (rw && eff > 0) chk("rd_start_latency", start_cyc, busy_n + 1);
         if (no_done)
            chk("timeout_window", (done_cyc - last_cyc >= int'(TMO)) &&
                                  (done_cyc - last_cyc <= int'(TMO) + 4), 1);
      end
   endtask

   initial begin
      logic [255:0] wd_seq, wd_rnd;
      bit rw_r, lv_r;
      int len_r;

      rst_n = 1'b0; ena = 1'b0; r_w = 1'b0; address_valid = 1'b0; address = '0;
      length_valid = 1'b0; length = '0; wr_data = '0; wr_data_valid = 1'b0;
      out_fsm_ready = 1'b0;
      engine_idle();
      repeat (3) @(negedge clk);
      #1 chk("reset_outputs", rst_vec(), RST_EXP);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_reset_outputs", rst_vec(), RST_EXP);

      for (int j = 0; j < 32; j++) wd_seq[8*j +: 8] = 8'(31 - j);
      for (int j = 0; j < 8; j++)  wd_rnd[32*j +: 32] = $urandom;

      // rw, addr, len, lv, wd, mode, seq, no_done, early, abort, busy
      run_txn(1, 24'h001234, 9'd16, 1, '0,     0, 1, 0, 0, 0, 0);
      run_txn(0, 24'h00ABCD, 9'd5,  0, wd_seq, 0, 0, 0, 0, 0, 0);
      run_txn(1, 24'h000100, 9'd8,  1, '0,     1, 1, 0, 0, 0, 0);
      run_txn(0, 24'h000200, 9'd0,  1, wd_seq, 0, 0, 0, 0, 0, 0);
      run_txn(1, 24'h000300, 9'd4,  1, '0,     0, 0, 1, 0, 0, 0);
      run_txn(1, 24'h000400, 9'd5,  1, '0,     2, 0, 0, 0, 0, 2);
      run_txn(1, 24'h000500, 9'd16, 1, '0,     0, 0, 0, 0, 1, 0);
      run_txn(1, 24'h000600, 9'd16, 1, '0,     0, 0, 0, 0, 0, 0);
      run_txn(0, 24'h000700, 9'd10, 1, wd_rnd, 2, 0, 0, 1, 0, 1);
      run_txn(0, 24'h000800, 9'd33, 1, wd_rnd, 0, 0, 0, 0, 0, 3);
      run_txn(1, 24'hFFFFFF, 9'd1,  1, '0,     1, 0, 0, 0, 0, 0);

      repeat (20) begin
         for (int j = 0; j < 8; j++) wd_rnd[32*j +: 32] = $urandom;
         rw_r  = 1'($urandom);
         lv_r  = ($urandom_range(0, 3) != 0);
         len_r = rw_r ? $urandom_range(1, 40) : $urandom_range(0, 40);
         run_txn(rw_r, 24'($urandom), 9'(len_r), lv_r, wd_rnd,
                 $urandom_range(0, 2), 0, 0, 0, 0, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
